stack_master: RTL

- Initiator for the 4-bit stack's COMMAND/INDEX/bidirectional-data protocol (NOP/PUSH/POP/GET).
- Accepts one request at a time from an upstream valid/ready port and sequences it onto the stack pins.
- Owns the turnaround of the shared data bus and captures POP/GET read data.
- Returns one response per request and keeps a shadow occupancy count to reject overflow/underflow/bad-index requests.

---
 rtl/stack_pkg.sv | 23 ++
 rtl/stack_master_if.sv | 44 ++++
 rtl/stack_bus_io.sv | 31 +++
 rtl/stack_master.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and defaults for the 4-bit stack, its master and its bench.
// Command encodings, master FSM states and default geometry.
package stack_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 5;
  localparam int IDX_W_DEF  = 3;

  typedef enum logic [1:0] {
    NOP  = 2'b00,
    PUSH = 2'b01,
    POP  = 2'b10,
    GET  = 2'b11
  } stack_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } master_state_t;

endpackage

// File: rtl/stack_master_if.sv
// Upstream request/response port of the stack master.
// master: the stack_master side; slave: the requester side.
interface stack_master_if
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
);

  logic              REQ_VALID;
  logic              REQ_READY;
  stack_cmd_t        REQ_CMD;
  logic [IDX_W-1:0]  REQ_INDEX;
  logic [DATA_W-1:0] REQ_DATA;
  logic              RSP_VALID;
  logic [DATA_W-1:0] RSP_DATA;
  logic              RSP_ERR;
  logic [IDX_W:0]    COUNT;

  modport master (
    input  REQ_VALID,
    input  REQ_CMD,
    input  REQ_INDEX,
    input  REQ_DATA,
    output REQ_READY,
    output RSP_VALID,
    output RSP_DATA,
    output RSP_ERR,
    output COUNT
  );

  modport slave (
    output REQ_VALID,
    output REQ_CMD,
    output REQ_INDEX,
    output REQ_DATA,
    input  REQ_READY,
    input  RSP_VALID,
    input  RSP_DATA,
    input  RSP_ERR,
    input  COUNT
  );

endinterface

// File: rtl/stack_bus_io.sv
// Tristate driver and capture register for the shared stack data bus.
// The capture register doubles as the response data holding register.
module stack_bus_io #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              oe_i,
  input  logic [DATA_W-1:0] dout_i,
  input  logic              smp_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] din_q_o,
  inout  wire  [DATA_W-1:0] pad_io
);

  logic [DATA_W-1:0] din_q;

  assign pad_io  = oe_i ? dout_i : {DATA_W{1'bz}};
  assign din_q_o = din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q <= '0;
    end else if (clr_i) begin
      din_q <= '0;
    end else if (smp_i) begin
      din_q <= pad_io;
    end
  end

endmodule

// File: rtl/stack_master.sv
// Initiator for the stack COMMAND/INDEX/data pins, one request in flight.
// STACK_MASTER_CHECK_EN: shadow occupancy count and illegal-request rejection.
module stack_master
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  stack_master_if.master    bus,
  output logic              S_RESET,
  output logic [1:0]        S_COMMAND,
  output logic [IDX_W-1:0]  S_INDEX,
  inout  wire  [DATA_W-1:0] S_DATA
);

  if ((1 << IDX_W) < DEPTH) begin : g_bad_geom
    $error("IDX_W too narrow for DEPTH");
  end

  master_state_t     state_q;
  stack_cmd_t        cmd_q;
  stack_cmd_t        s_cmd_q;
  logic [IDX_W-1:0]  s_idx_q;
  logic [DATA_W-1:0] data_q;
  logic              oe_q;
  logic              ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              s_reset_q;
  logic              hs;
  logic              illegal;
  logic              cap_en;
  logic              cap_clr;
  logic [DATA_W-1:0] cap_q;

  assign hs = bus.REQ_VALID && ready_q;

`ifdef STACK_MASTER_CHECK_EN
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);

  logic [IDX_W:0] count_q;
  logic [IDX_W:0] count_d;

  always_comb begin
    illegal = 1'b0;
    unique case (bus.REQ_CMD)
      PUSH:    illegal = (count_q == DEPTH_C);
      POP:     illegal = (count_q == '0);
      GET:     illegal = ({1'b0, bus.REQ_INDEX} >= count_q);
      default: illegal = 1'b0;
    endcase
  end

  // Occupancy follows what was actually issued to the stack.
  always_comb begin
    count_d = count_q;
    if (state_q == ST_ISSUE) begin
      unique case (cmd_q)
        PUSH:    count_d = count_q + 1'b1;
        POP:     count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.COUNT   = count_q;
  assign bus.RSP_ERR = rsp_err_q;
`else
  assign illegal     = 1'b0;
  assign bus.COUNT   = '0;
  assign bus.RSP_ERR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      cmd_q       <= NOP;
      s_cmd_q     <= NOP;
      s_idx_q     <= '0;
      data_q      <= '0;
      oe_q        <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      s_reset_q   <= 1'b1;
    end else begin
      s_reset_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (hs) begin
            ready_q <= 1'b0;
            cmd_q   <= bus.REQ_CMD;
            data_q  <= bus.REQ_DATA;
            if (illegal) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q <= ST_ISSUE;
              s_cmd_q <= bus.REQ_CMD;
              s_idx_q <= bus.REQ_INDEX;
              oe_q    <= (bus.REQ_CMD == PUSH);
            end
          end
        end
        ST_ISSUE: begin
          s_cmd_q <= NOP;
          s_idx_q <= '0;
          oe_q    <= 1'b0;
          if (cmd_q == POP || cmd_q == GET) begin
            state_q <= ST_CAPTURE;
          end else begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Responses without read data clear the held value to zero.
  assign cap_en  = (state_q == ST_CAPTURE);
  assign cap_clr = (state_q == ST_IDLE && hs && illegal) ||
                   (state_q == ST_ISSUE &&
                    cmd_q != POP && cmd_q != GET);

  stack_bus_io #(
    .DATA_W (DATA_W)
  ) u_io (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .oe_i    (oe_q),
    .dout_i  (data_q),
    .smp_i   (cap_en),
    .clr_i   (cap_clr),
    .din_q_o (cap_q),
    .pad_io  (S_DATA)
  );

  assign bus.REQ_READY = ready_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_DATA  = cap_q;
  assign S_RESET       = s_reset_q;
  assign S_COMMAND     = s_cmd_q;
  assign S_INDEX       = s_idx_q;

endmodule
